// File: rtl/ct_ifu_lbuf_fill_ctrl_pkg.sv
// +----------------------------------------------------------------------------+
// | Module : ct_ifu_lbuf_pkg                                                   |
// | Desc   : Loop buffer depth, pointer width and fill FSM state encoding.     |
// | Rev    : 1.0 - initial release                                             |
// +----------------------------------------------------------------------------+
`default_nettype none

package ct_ifu_lbuf_pkg;

   localparam int LBUF_DEPTH = 32;
   localparam int LBUF_PTR_W = 5;

   typedef enum logic [2:0] {
      IDLE  = 3'b001,
      FILL  = 3'b010,
      CACHE = 3'b100
   } lbuf_state_e;

endpackage

`default_nettype wire

// File: rtl/ct_ifu_lbuf_fill_ctrl_if.sv
// +----------------------------------------------------------------------------+
// | Module : ct_ifu_lbuf_fill_ctrl_if                                          |
// | Desc   : Fill/read control bundle; lbuf_iter_cnt exists only when          |
// |          CT_IFU_LBUF_ITER_CNT_EN is defined.                               |
// | Rev    : 1.0 - initial release                                             |
// +----------------------------------------------------------------------------+
`default_nettype none

interface ct_ifu_lbuf_fill_ctrl_if;
   import ct_ifu_lbuf_pkg::*;

   logic                  lbuf_flush;
   logic                  ip_lbuf_loop_vld;
   logic                  ip_lbuf_hw_vld;
   logic                  ip_lbuf_hw_back_br;
   logic                  ib_lbuf_pop;
   logic                  lbuf_exit;
   logic [LBUF_DEPTH-1:0] entry_create_x;
   logic                  fill_state_enter;
   logic                  lbuf_active;
   logic [LBUF_PTR_W-1:0] lbuf_rd_ptr;
   logic                  lbuf_fill_busy;
`ifdef CT_IFU_LBUF_ITER_CNT_EN
   logic [15:0]           lbuf_iter_cnt;
`endif

   modport master (
`ifdef CT_IFU_LBUF_ITER_CNT_EN
      input  lbuf_iter_cnt,
`endif
      output lbuf_flush, ip_lbuf_loop_vld, ip_lbuf_hw_vld, ip_lbuf_hw_back_br,
      output ib_lbuf_pop, lbuf_exit,
      input  entry_create_x, fill_state_enter, lbuf_active, lbuf_rd_ptr, lbuf_fill_busy
   );

   modport slave (
`ifdef CT_IFU_LBUF_ITER_CNT_EN
      output lbuf_iter_cnt,
`endif
      input  lbuf_flush, ip_lbuf_loop_vld, ip_lbuf_hw_vld, ip_lbuf_hw_back_br,
      input  ib_lbuf_pop, lbuf_exit,
      output entry_create_x, fill_state_enter, lbuf_active, lbuf_rd_ptr, lbuf_fill_busy
   );

endinterface

`default_nettype wire

// File: rtl/ct_ifu_lbuf_ptr_dec.sv
// +----------------------------------------------------------------------------+
// | Module : ct_ifu_lbuf_ptr_dec                                               |
// | Desc   : Enabled binary pointer to one-hot entry strobe decoder.           |
// | Rev    : 1.0 - initial release                                             |
// +----------------------------------------------------------------------------+
`default_nettype none

module ct_ifu_lbuf_ptr_dec
   import ct_ifu_lbuf_pkg::*;
(
   input  wire logic                  i_en,
   input  wire logic [LBUF_PTR_W-1:0] i_ptr,
   output logic      [LBUF_DEPTH-1:0] o_onehot
);

   generate
      for (genvar gi = 0; gi < LBUF_DEPTH; gi++) begin : g_dec
         assign o_onehot[gi] = i_en & (i_ptr == LBUF_PTR_W'(gi));
      end
   endgenerate

endmodule

`default_nettype wire

// File: rtl/ct_ifu_lbuf_fill_ctrl.sv
// +----------------------------------------------------------------------------+
// | Module : ct_ifu_lbuf_fill_ctrl                                             |
// | Desc   : Loop buffer fill/read FSM (IDLE -> FILL -> CACHE). Optional       |
// |          iteration counter under CT_IFU_LBUF_ITER_CNT_EN.                  |
// | Rev    : 1.0 - initial release                                             |
// +----------------------------------------------------------------------------+
`default_nettype none

module ct_ifu_lbuf_fill_ctrl
   import ct_ifu_lbuf_pkg::*;
(
   input  wire logic              lbuf_vld_update_clk,
   input  wire logic              cpurst_b,
   ct_ifu_lbuf_fill_ctrl_if.slave lbuf_if
);

   lbuf_state_e           r_state;
   logic [LBUF_PTR_W-1:0] r_wr_ptr;
   logic [LBUF_PTR_W-1:0] r_rd_ptr;
   logic [LBUF_PTR_W-1:0] r_end_ptr;

   logic w_enter_fill;
   logic w_fill_wr;

   // cpurst_b gate keeps the combinational pulse quiet while reset is held
   assign w_enter_fill = cpurst_b & (r_state == IDLE) & lbuf_if.ip_lbuf_loop_vld
                         & ~lbuf_if.lbuf_flush;
   assign w_fill_wr    = (r_state == FILL) & lbuf_if.ip_lbuf_hw_vld & ~lbuf_if.lbuf_flush;

   ct_ifu_lbuf_ptr_dec u_wr_dec (
      .i_en     (w_fill_wr),
      .i_ptr    (r_wr_ptr),
      .o_onehot (lbuf_if.entry_create_x)
   );

   always_ff @(posedge lbuf_vld_update_clk or negedge cpurst_b) begin
      if (!cpurst_b) begin
         r_state   <= IDLE;
         r_wr_ptr  <= '0;
         r_rd_ptr  <= '0;
         r_end_ptr <= '0;
      end else if (lbuf_if.lbuf_flush) begin
         r_state <= IDLE;
      end else begin
         case (r_state)
            IDLE: begin
               if (lbuf_if.ip_lbuf_loop_vld) begin
                  r_state  <= FILL;
                  r_wr_ptr <= '0;
               end
            end
            FILL: begin
               if (lbuf_if.ip_lbuf_hw_vld) begin
                  r_wr_ptr <= r_wr_ptr + 1'b1;
                  if (lbuf_if.ip_lbuf_hw_back_br) begin
                     r_end_ptr <= r_wr_ptr;
                     r_rd_ptr  <= '0;
                     r_state   <= CACHE;
                  end else if (r_wr_ptr == LBUF_PTR_W'(LBUF_DEPTH - 1)) begin
                     r_state <= IDLE;
                  end
               end
            end
            CACHE: begin
               // exit wins over a coincident pop
               if (lbuf_if.lbuf_exit) begin
                  r_state <= IDLE;
               end else if (lbuf_if.ib_lbuf_pop) begin
                  r_rd_ptr <= (r_rd_ptr == r_end_ptr) ? '0 : r_rd_ptr + 1'b1;
               end
            end
            default: r_state <= IDLE;
         endcase
      end
   end

`ifdef CT_IFU_LBUF_ITER_CNT_EN
   logic [15:0] r_iter_cnt;
   logic        w_wrap_pop;

   assign w_wrap_pop = (r_state == CACHE) & lbuf_if.ib_lbuf_pop & ~lbuf_if.lbuf_exit
                       & ~lbuf_if.lbuf_flush & (r_rd_ptr == r_end_ptr);

   always_ff @(posedge lbuf_vld_update_clk or negedge cpurst_b) begin
      if (!cpurst_b) begin
         r_iter_cnt <= '0;
      end else if (w_enter_fill) begin
         r_iter_cnt <= '0;
      end else if (w_wrap_pop && (r_iter_cnt != 16'hFFFF)) begin
         r_iter_cnt <= r_iter_cnt + 16'd1;
      end
   end

   assign lbuf_if.lbuf_iter_cnt = r_iter_cnt;
`endif

   assign lbuf_if.fill_state_enter = w_enter_fill;
   assign lbuf_if.lbuf_active      = (r_state == CACHE);
   assign lbuf_if.lbuf_fill_busy   = (r_state == FILL);
   assign lbuf_if.lbuf_rd_ptr      = r_rd_ptr;

endmodule

`default_nettype wire

// File: tb/tb_ct_ifu_lbuf_fill_ctrl.sv
// +----------------------------------------------------------------------------+
// | Module : tb_ct_ifu_lbuf_fill_ctrl                                          |
// | Desc   : Vector table, directed corner sequences and random stimulus       |
// |          against a queue-based loop buffer model.                          |
// | Rev    : 1.0 - initial release                                             |
// +----------------------------------------------------------------------------+
`default_nettype none

module tb_ct_ifu_lbuf_fill_ctrl;
   import ct_ifu_lbuf_pkg::*;

   logic clk = 1'b0;
   logic rst_b;
   always #5 clk = ~clk;

   ct_ifu_lbuf_fill_ctrl_if lif ();

   ct_ifu_lbuf_fill_ctrl dut (
      .lbuf_vld_update_clk (clk),
      .cpurst_b            (rst_b),
      .lbuf_if             (lif)
   );

   typedef struct {
      bit flush, loop, hw, br, pop, ex;
   } stim_t;

   typedef struct {
      stim_t       s;
      logic [31:0] create;
      bit          fse, act, busy;
      int          rd;
   } vec_t;

   int n_vec = 0;
   int n_err = 0;
   stim_t cur;

   // model: 0 idle, 1 fill, 2 cache; read position derived from pops and loop length
   int m_mode, m_len, m_pops, m_rd_frozen;
   int fill_q[$];

   function automatic stim_t mk(bit fl, bit lp, bit hw, bit br, bit pop, bit ex);
      stim_t s;
      s.flush = fl; s.loop = lp; s.hw = hw; s.br = br; s.pop = pop; s.ex = ex;
      return s;
   endfunction

   function automatic int m_rd();
      return (m_len == 0) ? m_rd_frozen : (m_pops % m_len);
   endfunction

   function automatic int m_iter();
      int it;
      it = (m_len == 0) ? 0 : (m_pops / m_len);
      return (it > 65535) ? 65535 : it;
   endfunction

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
      end
   endtask

   task automatic model_reset();
      m_mode = 0; m_len = 0; m_pops = 0; m_rd_frozen = 0;
      fill_q.delete();
   endtask

   task automatic model_check();
      logic [31:0] c;
      c = '0;
      if (m_mode == 1 && cur.hw && !cur.flush) c[fill_q.size()] = 1'b1;
      chk("m_create", lif.entry_create_x, c);
      chk("m_fse",    lif.fill_state_enter, (m_mode == 0 && cur.loop && !cur.flush));
      chk("m_active", lif.lbuf_active, (m_mode == 2));
      chk("m_busy",   lif.lbuf_fill_busy, (m_mode == 1));
      chk("m_rd",     lif.lbuf_rd_ptr, m_rd());
`ifdef CT_IFU_LBUF_ITER_CNT_EN
      chk("m_iter",   lif.lbuf_iter_cnt, m_iter());
`endif
   endtask

   task automatic model_step();
      if (cur.flush) begin
         m_mode = 0;
      end else if (m_mode == 0) begin
         if (cur.loop) begin
            m_rd_frozen = m_rd();
            m_len = 0; m_pops = 0;
            fill_q.delete();
            m_mode = 1;
         end
      end else if (m_mode == 1) begin
         if (cur.hw) begin
            fill_q.push_back(fill_q.size());
            if (cur.br) begin
               m_len = fill_q.size(); m_pops = 0; m_mode = 2;
            end else if (fill_q.size() == LBUF_DEPTH) begin
               m_mode = 0;
            end
         end
      end else begin
         if (cur.ex) m_mode = 0;
         else if (cur.pop) m_pops++;
      end
   endtask

   task automatic apply(input stim_t s);
      cur = s;
      lif.lbuf_flush         = s.flush;
      lif.ip_lbuf_loop_vld   = s.loop;
      lif.ip_lbuf_hw_vld     = s.hw;
      lif.ip_lbuf_hw_back_br = s.br;
      lif.ib_lbuf_pop        = s.pop;
      lif.lbuf_exit          = s.ex;
      #1;
      if (rst_b) model_check();
   endtask

   task automatic advance();
      @(posedge clk);
      if (rst_b) model_step();
      @(negedge clk);
   endtask

   task automatic step(input stim_t s);
      apply(s);
      advance();
   endtask

   initial begin
      vec_t tbl[21];

      rst_b = 1'b0;
      model_reset();
      apply(mk(0, 0, 0, 0, 0, 0));
      repeat (2) @(negedge clk);
      #1;
      chk("rst_create", lif.entry_create_x, 0);
      chk("rst_busy",   lif.lbuf_fill_busy, 0);
      chk("rst_active", lif.lbuf_active, 0);
      chk("rst_rd",     lif.lbuf_rd_ptr, 0);
      rst_b = 1'b1;
      @(negedge clk);

      // normal fill of six halfwords then thirteen pops
      for (int i = 0; i < 21; i++) begin
         tbl[i].s = mk(0, 0, 0, 0, 0, 0);
         tbl[i].create = '0; tbl[i].fse = 0; tbl[i].act = 0; tbl[i].busy = 0; tbl[i].rd = 0;
      end
      tbl[0].s = mk(0, 1, 0, 0, 0, 0); tbl[0].fse = 1;
      for (int k = 0; k < 6; k++) begin
         tbl[1+k].s = mk(0, 0, 1, (k == 5), 0, 0);
         tbl[1+k].create = 32'(1) << k;
         tbl[1+k].busy = 1;
      end
      for (int k = 0; k < 13; k++) begin
         tbl[7+k].s = mk(0, 0, 0, 0, 1, 0);
         tbl[7+k].act = 1; tbl[7+k].rd = k % 6;
      end
      tbl[20].act = 1; tbl[20].rd = 1;

      for (int i = 0; i < 21; i++) begin
         apply(tbl[i].s);
         chk($sformatf("tbl%0d_create", i), lif.entry_create_x, tbl[i].create);
         chk($sformatf("tbl%0d_fse", i),    lif.fill_state_enter, tbl[i].fse);
         chk($sformatf("tbl%0d_active", i), lif.lbuf_active, tbl[i].act);
         chk($sformatf("tbl%0d_busy", i),   lif.lbuf_fill_busy, tbl[i].busy);
         chk($sformatf("tbl%0d_rd", i),     lif.lbuf_rd_ptr, tbl[i].rd);
`ifdef CT_IFU_LBUF_ITER_CNT_EN
         if (i == 20) chk("tbl_iter", lif.lbuf_iter_cnt, 2);
`endif
         advance();
      end
      step(mk(1, 0, 0, 0, 0, 0));

      // asynchronous reset while reading entry 7
      step(mk(0, 1, 0, 0, 0, 0));
      for (int k = 0; k < 10; k++) step(mk(0, 0, 1, (k == 9), 0, 0));
      repeat (7) step(mk(0, 0, 0, 0, 1, 0));
      apply(mk(0, 1, 1, 0, 1, 0));
      chk("pre_rst_rd", lif.lbuf_rd_ptr, 7);
      chk("pre_rst_active", lif.lbuf_active, 1);
      rst_b = 1'b0;
      #1;
      chk("arst_create", lif.entry_create_x, 0);
      chk("arst_fse",    lif.fill_state_enter, 0);
      chk("arst_active", lif.lbuf_active, 0);
      chk("arst_busy",   lif.lbuf_fill_busy, 0);
      chk("arst_rd",     lif.lbuf_rd_ptr, 0);
`ifdef CT_IFU_LBUF_ITER_CNT_EN
      chk("arst_iter",   lif.lbuf_iter_cnt, 0);
`endif
      model_reset();
      advance();
      rst_b = 1'b1;
      apply(mk(0, 1, 0, 0, 0, 0));
      chk("post_rst_fse", lif.fill_state_enter, 1);
      chk("post_rst_busy", lif.lbuf_fill_busy, 0);
      advance();
      apply(mk(0, 0, 0, 0, 0, 0));
      chk("post_rst_fill", lif.lbuf_fill_busy, 1);
      advance();
      step(mk(1, 0, 0, 0, 0, 0));

      // abort after 32 writes without a backward branch
      step(mk(0, 1, 0, 0, 0, 0));
      for (int k = 0; k < 32; k++) begin
         apply(mk(0, 0, 1, 0, 0, 0));
         chk($sformatf("abort_create%0d", k), lif.entry_create_x, 32'(1) << k);
         advance();
      end
      apply(mk(0, 0, 1, 0, 0, 0));
      chk("abort_no33", lif.entry_create_x, 0);
      chk("abort_idle", lif.lbuf_fill_busy, 0);
      advance();

      // flush priority
      apply(mk(1, 1, 0, 0, 0, 0));
      chk("flush_idle_fse", lif.fill_state_enter, 0);
      advance();
      apply(mk(0, 0, 0, 0, 0, 0));
      chk("flush_idle_busy", lif.lbuf_fill_busy, 0);
      advance();
      step(mk(0, 1, 0, 0, 0, 0));
      apply(mk(1, 0, 1, 0, 0, 0));
      chk("flush_fill_create", lif.entry_create_x, 0);
      advance();
      apply(mk(0, 0, 0, 0, 0, 0));
      chk("flush_fill_busy", lif.lbuf_fill_busy, 0);
      chk("flush_fill_active", lif.lbuf_active, 0);
      advance();
      step(mk(0, 1, 0, 0, 0, 0));
      step(mk(0, 0, 1, 1, 0, 0));
      step(mk(1, 0, 0, 0, 1, 0));
      apply(mk(0, 0, 0, 0, 0, 0));
      chk("flush_cache_active", lif.lbuf_active, 0);
      advance();

      // pop and exit together at end_ptr
      step(mk(0, 1, 0, 0, 0, 0));
      for (int k = 0; k < 3; k++) step(mk(0, 0, 1, (k == 2), 0, 0));
      repeat (5) step(mk(0, 0, 0, 0, 1, 0));
      apply(mk(0, 0, 0, 0, 1, 1));
      chk("popexit_rd_before", lif.lbuf_rd_ptr, 2);
      advance();
      apply(mk(0, 0, 0, 0, 0, 0));
      chk("popexit_active", lif.lbuf_active, 0);
      chk("popexit_rd", lif.lbuf_rd_ptr, 2);
`ifdef CT_IFU_LBUF_ITER_CNT_EN
      chk("popexit_iter", lif.lbuf_iter_cnt, 1);
`endif
      advance();

      // loop_vld ignored while in CACHE
      step(mk(0, 1, 0, 0, 0, 0));
      step(mk(0, 0, 1, 1, 0, 0));
      apply(mk(0, 1, 0, 0, 0, 0));
      chk("cache_loop_fse", lif.fill_state_enter, 0);
      advance();
      apply(mk(0, 0, 0, 0, 0, 0));
      chk("cache_loop_active", lif.lbuf_active, 1);
      chk("cache_loop_busy", lif.lbuf_fill_busy, 0);
      advance();

      // random traffic against the model
      for (int n = 0; n < 3000; n++) begin
         step(mk(($urandom_range(0, 99) == 0),
                 ($urandom_range(0, 2) == 0),
                 ($urandom_range(0, 3) != 0),
                 ($urandom_range(0, 9) == 0),
                 ($urandom_range(0, 1) == 0),
                 ($urandom_range(0, 39) == 0)));
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule

`default_nettype wire
